// File: rtl/regfile_sb.sv
// Scoreboarded register file: NUM_RD combinational read ports, ALU (A) and load (B) write ports,
// per-register busy tracking for outstanding loads. Optional same-cycle forwarding under REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int WORD_WIDTH = 16,
    parameter int IDX_WIDTH  = 4,
    parameter int NUM_RD     = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_RD*IDX_WIDTH-1:0]  in_src_idx,
    output logic [NUM_RD*WORD_WIDTH-1:0] out_src,
    output logic [NUM_RD-1:0]            out_src_busy,
    input  logic                         in_wa_en,
    input  logic [IDX_WIDTH-1:0]         in_wa_idx,
    input  logic [WORD_WIDTH-1:0]        in_wa_data,
    input  logic                         in_wb_en,
    input  logic [IDX_WIDTH-1:0]         in_wb_idx,
    input  logic [WORD_WIDTH-1:0]        in_wb_data,
    input  logic                         in_issue,
    input  logic [IDX_WIDTH-1:0]         in_issue_idx,
    output logic [IDX_WIDTH:0]           out_pending,
    output logic                         out_wr_conflict
);
    localparam int NUM_REGS = 1 << IDX_WIDTH;

    logic [WORD_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [IDX_WIDTH:0]    pending_next;
    logic                  wa_hit;
    logic                  wb_hit;
    logic                  issue_hit;
    logic                  same_dst;

    assign wa_hit    = in_wa_en && (in_wa_idx != '0);
    assign wb_hit    = in_wb_en && (in_wb_idx != '0);
    assign issue_hit = in_issue && (in_issue_idx != '0);
    assign same_dst  = wa_hit && wb_hit && (in_wa_idx == in_wb_idx);

    // Set is applied after clear so a newly issued load wins over a completing one.
    always_comb begin
        busy_next = busy;
        if (wb_hit) busy_next[in_wb_idx] = 1'b0;
        if (issue_hit) busy_next[in_issue_idx] = 1'b1;
    end

    always_comb begin
        pending_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_next = pending_next + {{IDX_WIDTH{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy            <= '0;
            out_pending     <= '0;
            out_wr_conflict <= 1'b0;
        end else begin
            if (wa_hit && !same_dst) regs[in_wa_idx] <= in_wa_data;
            if (wb_hit) regs[in_wb_idx] <= in_wb_data;
            busy            <= busy_next;
            out_pending     <= pending_next;
            out_wr_conflict <= same_dst;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [IDX_WIDTH-1:0]  idx;
        logic [WORD_WIDTH-1:0] data;
        logic                  bsy;

        assign idx = in_src_idx[k*IDX_WIDTH +: IDX_WIDTH];

        always_comb begin
            data = (idx == '0) ? '0 : regs[idx];
            bsy  = busy[idx];
`ifdef REGFILE_BYPASS_EN
            // Port B has priority, matching the storage rule on a same-index collision.
            if (idx != '0) begin
                if (wb_hit && (in_wb_idx == idx)) begin
                    data = in_wb_data;
                    if (!(issue_hit && (in_issue_idx == idx))) bsy = 1'b0;
                end else if (wa_hit && (in_wa_idx == idx)) begin
                    data = in_wa_data;
                end
            end
`endif
        end

        assign out_src[k*WORD_WIDTH +: WORD_WIDTH] = data;
        assign out_src_busy[k]                     = bsy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (two read ports); expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;
    localparam int W  = 16;
    localparam int IW = 4;
    localparam int NR = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR*IW-1:0]  in_src_idx;
    logic [NR*W-1:0]   out_src;
    logic [NR-1:0]     out_src_busy;
    logic              in_wa_en;
    logic [IW-1:0]     in_wa_idx;
    logic [W-1:0]      in_wa_data;
    logic              in_wb_en;
    logic [IW-1:0]     in_wb_idx;
    logic [W-1:0]      in_wb_data;
    logic              in_issue;
    logic [IW-1:0]     in_issue_idx;
    logic [IW:0]       out_pending;
    logic              out_wr_conflict;

    int tests = 0;
    int fails = 0;

    regfile_sb #(.WORD_WIDTH(W), .IDX_WIDTH(IW), .NUM_RD(NR)) dut (
        .clock(clock),
        .reset(reset),
        .in_src_idx(in_src_idx),
        .out_src(out_src),
        .out_src_busy(out_src_busy),
        .in_wa_en(in_wa_en),
        .in_wa_idx(in_wa_idx),
        .in_wa_data(in_wa_data),
        .in_wb_en(in_wb_en),
        .in_wb_idx(in_wb_idx),
        .in_wb_data(in_wb_data),
        .in_issue(in_issue),
        .in_issue_idx(in_issue_idx),
        .out_pending(out_pending),
        .out_wr_conflict(out_wr_conflict)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_wa_en = 1'b0; in_wa_idx = '0; in_wa_data = '0;
        in_wb_en = 1'b0; in_wb_idx = '0; in_wb_data = '0;
        in_issue = 1'b0; in_issue_idx = '0;
    endtask

    task automatic set_rd(input logic [IW-1:0] i0, input logic [IW-1:0] i1);
        in_src_idx = {i1, i0};
        #1;
    endtask

    // Inputs change 1 time unit after the rising edge, leaving the rest of the cycle to settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_a(input logic [IW-1:0] idx, input logic [W-1:0] data);
        in_wa_en = 1'b1; in_wa_idx = idx; in_wa_data = data;
    endtask

    task automatic write_b(input logic [IW-1:0] idx, input logic [W-1:0] data);
        in_wb_en = 1'b1; in_wb_idx = idx; in_wb_data = data;
    endtask

    task automatic issue(input logic [IW-1:0] idx);
        in_issue = 1'b1; in_issue_idx = idx;
    endtask

    initial begin
        logic [IW-1:0] ia;
        logic [IW-1:0] ib;
        reset = 1'b1;
        in_src_idx = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state across every index
        for (int i = 0; i < 16; i++) begin
            ia = IW'(i);
            ib = IW'(15 - i);
            set_rd(ia, ib);
            check("rst_src0", {16'h0, out_src[15:0]}, 32'h0);
            check("rst_src1", {16'h0, out_src[31:16]}, 32'h0);
            check("rst_busy", {30'h0, out_src_busy}, 32'h0);
        end
        check("rst_pending", {27'h0, out_pending}, 32'h0);
        check("rst_conflict", {31'h0, out_wr_conflict}, 32'h0);

        // A to idx 3 while B targets idx 0
        write_a(4'd3, 16'h1234);
        write_b(4'd0, 16'hFFFF);
        set_rd(4'd3, 4'd0);
`ifdef REGFILE_BYPASS_EN
        check("fwd_a_idx3", {16'h0, out_src[15:0]}, 32'h1234);
`else
        check("pre_idx3", {16'h0, out_src[15:0]}, 32'h0);
`endif
        check("pre_idx0", {16'h0, out_src[31:16]}, 32'h0);
        tick();
        idle();
        set_rd(4'd3, 4'd0);
        check("wa_idx3", {16'h0, out_src[15:0]}, 32'h1234);
        check("wb_idx0", {16'h0, out_src[31:16]}, 32'h0);
        check("no_conflict_idx0", {31'h0, out_wr_conflict}, 32'h0);
        check("pending_after_writes", {27'h0, out_pending}, 32'h0);

        // Same-index A/B collision
        write_a(4'd5, 16'hAAAA);
        write_b(4'd5, 16'h5555);
        tick();
        idle();
        set_rd(4'd5, 4'd3);
        check("collide_idx5", {16'h0, out_src[15:0]}, 32'h5555);
        check("collide_keep3", {16'h0, out_src[31:16]}, 32'h1234);
        check("conflict_pulse", {31'h0, out_wr_conflict}, 32'h1);
        tick();
        check("conflict_drop", {31'h0, out_wr_conflict}, 32'h0);

        // Scoreboard set
        issue(4'd7);
        tick();
        idle();
        check("pending_1", {27'h0, out_pending}, 32'h1);
        issue(4'd9);
        tick();
        idle();
        set_rd(4'd7, 4'd9);
        check("pending_2", {27'h0, out_pending}, 32'h2);
        check("busy_7_9", {30'h0, out_src_busy}, 32'h3);

        // Completion and re-issue to the same index in one cycle
        write_b(4'd7, 16'h0042);
        issue(4'd7);
        tick();
        idle();
        set_rd(4'd7, 4'd9);
        check("reissue_data7", {16'h0, out_src[15:0]}, 32'h0042);
        check("reissue_busy", {30'h0, out_src_busy}, 32'h3);
        check("reissue_pending", {27'h0, out_pending}, 32'h2);

        // Port A write into a busy register leaves busy alone
        write_a(4'd9, 16'h1111);
        tick();
        idle();
        set_rd(4'd9, 4'd0);
        check("wa_busy_data9", {16'h0, out_src[15:0]}, 32'h1111);
        check("wa_busy_flag9", {30'h0, out_src_busy}, 32'h1);
        check("wa_busy_pending", {27'h0, out_pending}, 32'h2);

        // Load completion seen on a read port in the same cycle
        issue(4'd4);
        tick();
        idle();
        check("pending_3", {27'h0, out_pending}, 32'h3);
        write_b(4'd4, 16'hBEEF);
        set_rd(4'd4, 4'd9);
`ifdef REGFILE_BYPASS_EN
        check("same_cyc_data4", {16'h0, out_src[15:0]}, 32'hBEEF);
        check("same_cyc_busy", {30'h0, out_src_busy}, 32'h2);
`else
        check("same_cyc_data4", {16'h0, out_src[15:0]}, 32'h0);
        check("same_cyc_busy", {30'h0, out_src_busy}, 32'h3);
`endif
        tick();
        idle();
        set_rd(4'd4, 4'd9);
        check("next_cyc_data4", {16'h0, out_src[15:0]}, 32'hBEEF);
        check("next_cyc_busy", {30'h0, out_src_busy}, 32'h2);
        check("pending_after_clear", {27'h0, out_pending}, 32'h2);

        // Issue to idx 0 is ignored
        issue(4'd0);
        tick();
        idle();
        set_rd(4'd0, 4'd0);
        check("issue0_busy", {30'h0, out_src_busy}, 32'h0);
        check("issue0_pending", {27'h0, out_pending}, 32'h2);

        // Reset mid-operation, overriding a concurrent write and issue
        issue(4'd2);
        tick();
        issue(4'd6);
        tick();
        idle();
        check("pending_4", {27'h0, out_pending}, 32'h4);
        reset = 1'b1;
        write_a(4'd8, 16'h7777);
        issue(4'd10);
        tick();
        reset = 1'b0;
        idle();
        set_rd(4'd8, 4'd10);
        check("mid_rst_pending", {27'h0, out_pending}, 32'h0);
        check("mid_rst_data8", {16'h0, out_src[15:0]}, 32'h0);
        check("mid_rst_busy", {30'h0, out_src_busy}, 32'h0);
        set_rd(4'd3, 4'd2);
        check("mid_rst_data3", {16'h0, out_src[15:0]}, 32'h0);
        write_b(4'd2, 16'h0001);
        tick();
        idle();
        set_rd(4'd2, 4'd6);
        check("post_rst_data2", {16'h0, out_src[15:0]}, 32'h0001);
        check("post_rst_busy", {30'h0, out_src_busy}, 32'h0);
        check("post_rst_pending", {27'h0, out_pending}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
